management_tx_arbiter: RTL and testbench

// Frame-granular round-robin arbiter sharing the management 10G TX EthernetTxBus among NUM_SRC frame sources.

---
 rtl/management_tx_arbiter_pkg.sv | 18 +
 rtl/management_tx_arbiter_picker.sv | 27 ++
 rtl/management_tx_arbiter.sv | 168 ++++++++++++++++
 tb/tb_management_tx_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/management_tx_arbiter_pkg.sv
// Shared types for the management TX path: MAC-side bus struct and arbiter state encoding.
`timescale 1ns/1ps
package EthernetBus;
    typedef struct packed {
        logic        start;
        logic        data_valid;
        logic [2:0]  bytes_valid;
        logic [31:0] data;
    } EthernetTxBus;
endpackage

package MgmtTxArbPkg;
    typedef enum logic [1:0] {IDLE, HDR_WAIT, SEND, GAP} mgmt_tx_state_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/management_tx_arbiter_picker.sv
// Combinational round-robin pick: first requesting index at or after the pointer, wrapping.
`timescale 1ns/1ps
module mgmt_rr_picker #(
    parameter int NUM_SRC = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_SRC-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_found
);
    function automatic logic [IDX_W-1:0] wrap(input int v);
        return IDX_W'(v % NUM_SRC);
    endfunction

    // Scan from the farthest offset down so the nearest request wins.
    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (i_req[wrap(int'(i_ptr) + i)]) begin
                o_idx   = wrap(int'(i_ptr) + i);
                o_found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/management_tx_arbiter.sv
// Frame-granular round-robin arbiter feeding the management 10G MAC from NUM_SRC header/data FIFO pairs.
`timescale 1ns/1ps
module management_tx_arbiter
    import EthernetBus::*;
    import MgmtTxArbPkg::*;
#(
    parameter int NUM_SRC       = 2,
    parameter int LEN_WIDTH     = 11,
    parameter int RD_LATENCY    = 2,
    parameter int MAX_LEN_WORDS = 1024,
    parameter int IFG_CYCLES    = 3,
    localparam int IDX_W        = idx_width(NUM_SRC)
) (
    input  logic                                i_tx_clk,
    input  logic                                i_tx_reset,
    input  logic                                i_link_up,
    input  logic [NUM_SRC-1:0]                  i_src_hdr_avail,
    input  logic [NUM_SRC-1:0][LEN_WIDTH-1:0]   i_src_hdr_len,
    output logic [NUM_SRC-1:0]                  o_src_hdr_pop,
    input  logic [NUM_SRC-1:0][31:0]            i_src_data,
    input  logic [NUM_SRC-1:0][2:0]             i_src_bytes_valid,
    output logic [NUM_SRC-1:0]                  o_src_data_pop,
    output EthernetTxBus                        o_tx_bus,
    output logic                                o_grant_valid,
    output logic [IDX_W-1:0]                    o_grant_idx,
    output logic [15:0]                         o_frames_sent,
    output logic [15:0]                         o_frames_dropped
);
    localparam int GAP_LEN = IFG_CYCLES + RD_LATENCY + 1;
    localparam int GAP_W   = $clog2(GAP_LEN + 1);
    localparam int CNT_W   = (LEN_WIDTH > GAP_W) ? LEN_WIDTH : GAP_W;
    localparam logic [LEN_WIDTH:0] MAX_LEN = (LEN_WIDTH + 1)'(MAX_LEN_WORDS);

    mgmt_tx_state_e r_state, w_state_nxt;
    logic [IDX_W-1:0] r_rr, w_rr_nxt, r_grant_idx, w_gidx_nxt, w_pick;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_drop, w_drop_nxt, w_found;
    logic             w_hdr_pop_nxt, w_pop_nxt, w_first_nxt, w_sent_inc, w_drop_inc;
    logic [LEN_WIDTH-1:0] w_len;
    logic [NUM_SRC-1:0]   w_onehot;

    // Stage k of the delay line describes the pop issued k cycles ago.
    logic [RD_LATENCY:0]            r_vld_pipe, r_start_pipe, r_drop_pipe;
    logic [RD_LATENCY:0][IDX_W-1:0] r_idx_pipe;
    logic                           w_beat;

    mgmt_rr_picker #(.NUM_SRC(NUM_SRC), .IDX_W(IDX_W)) u_picker (
        .i_req   (i_src_hdr_avail),
        .i_ptr   (r_rr),
        .o_idx   (w_pick),
        .o_found (w_found)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_drop_nxt    = r_drop;
        w_rr_nxt      = r_rr;
        w_gidx_nxt    = r_grant_idx;
        w_hdr_pop_nxt = 1'b0;
        w_pop_nxt     = 1'b0;
        w_first_nxt   = 1'b0;
        w_sent_inc    = 1'b0;
        w_drop_inc    = 1'b0;
        w_len         = i_src_hdr_len[r_grant_idx];
        case (r_state)
            IDLE: if (i_link_up && w_found) begin
                w_state_nxt   = HDR_WAIT;
                w_gidx_nxt    = w_pick;
                w_hdr_pop_nxt = 1'b1;
                w_cnt_nxt     = '0;
                w_rr_nxt      = (w_pick == IDX_W'(NUM_SRC - 1)) ? '0 : w_pick + 1'b1;
            end
            HDR_WAIT: begin
                if (r_cnt == CNT_W'(RD_LATENCY)) begin
                    if (w_len == '0) begin
                        w_state_nxt = GAP;
                        w_cnt_nxt   = CNT_W'(GAP_LEN - 1);
                    end else begin
                        w_state_nxt = SEND;
                        w_pop_nxt   = 1'b1;
                        w_first_nxt = 1'b1;
                        w_drop_nxt  = ({1'b0, w_len} > MAX_LEN) || !i_link_up;
                        w_cnt_nxt   = CNT_W'(w_len - 1'b1);
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            // r_cnt holds pops still to issue after the one currently on the port.
            SEND: begin
                if (r_cnt != '0) begin
                    w_pop_nxt  = 1'b1;
                    w_drop_nxt = r_drop || !i_link_up;
                    w_cnt_nxt  = r_cnt - 1'b1;
                end else begin
                    w_state_nxt = GAP;
                    w_cnt_nxt   = CNT_W'(GAP_LEN - 1);
                end
            end
            GAP: begin
                if (r_cnt == '0) w_state_nxt = IDLE;
                else             w_cnt_nxt   = r_cnt - 1'b1;
            end
            default: w_state_nxt = IDLE;
        endcase
        if (w_pop_nxt && w_cnt_nxt == '0) begin
            w_sent_inc = !w_drop_nxt;
            w_drop_inc = w_drop_nxt;
        end
        w_onehot = NUM_SRC'(1) << w_gidx_nxt;
    end

    always_ff @(posedge i_tx_clk) begin
        if (i_tx_reset) begin
            r_state        <= IDLE;
            r_rr           <= '0;
            r_cnt          <= '0;
            r_drop         <= 1'b0;
            r_grant_idx    <= '0;
            o_grant_idx    <= '0;
            o_grant_valid  <= 1'b0;
            o_src_hdr_pop  <= '0;
            o_src_data_pop <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_rr           <= w_rr_nxt;
            r_cnt          <= w_cnt_nxt;
            r_drop         <= w_drop_nxt;
            r_grant_idx    <= w_gidx_nxt;
            o_grant_idx    <= w_gidx_nxt;
            o_grant_valid  <= (w_state_nxt != IDLE);
            o_src_hdr_pop  <= w_hdr_pop_nxt ? w_onehot : '0;
            o_src_data_pop <= w_pop_nxt ? w_onehot : '0;
        end
    end

    assign w_beat = r_vld_pipe[RD_LATENCY] && !r_drop_pipe[RD_LATENCY];

    always_ff @(posedge i_tx_clk) begin
        if (i_tx_reset) begin
            r_vld_pipe       <= '0;
            r_start_pipe     <= '0;
            r_drop_pipe      <= '0;
            r_idx_pipe       <= '0;
            o_tx_bus         <= '0;
            o_frames_sent    <= '0;
            o_frames_dropped <= '0;
        end else begin
            r_vld_pipe[0]   <= w_pop_nxt;
            r_start_pipe[0] <= w_first_nxt;
            r_drop_pipe[0]  <= w_drop_nxt;
            r_idx_pipe[0]   <= w_gidx_nxt;
            for (int i = 1; i <= RD_LATENCY; i++) begin
                r_vld_pipe[i]   <= r_vld_pipe[i-1];
                r_start_pipe[i] <= r_start_pipe[i-1];
                r_drop_pipe[i]  <= r_drop_pipe[i-1];
                r_idx_pipe[i]   <= r_idx_pipe[i-1];
            end
            o_tx_bus.start       <= w_beat && r_start_pipe[RD_LATENCY];
            o_tx_bus.data_valid  <= w_beat;
            o_tx_bus.data        <= w_beat ? i_src_data[r_idx_pipe[RD_LATENCY]] : '0;
            o_tx_bus.bytes_valid <= w_beat ? i_src_bytes_valid[r_idx_pipe[RD_LATENCY]] : '0;
            if (w_sent_inc) o_frames_sent <= o_frames_sent + 16'd1;
            if (w_drop_inc && o_frames_dropped != 16'hffff) o_frames_dropped <= o_frames_dropped + 16'd1;
        end
    end
endmodule

// File: tb/tb_management_tx_arbiter.sv
// Directed bench: FIFO models with 2-cycle read latency, beat scoreboard, frame vector table, corner sequences.
`timescale 1ns/1ps
module tb_management_tx_arbiter;
    import EthernetBus::*;

    logic              clk = 1'b0;
    logic              rst, link;
    logic [1:0]        hdr_avail = '0, hdr_pop, data_pop;
    logic [1:0][10:0]  hdr_len = '0, h_s1 = '0;
    logic [1:0][34:0]  d_s1 = '0, d_out = '0;
    logic [1:0][31:0]  sdata;
    logic [1:0][2:0]   sbv;
    EthernetTxBus      txb;
    logic              gv;
    logic [0:0]        gidx;
    logic [15:0]       fsent, fdrop;

    always #5 clk = ~clk;

    management_tx_arbiter dut (
        .i_tx_clk(clk), .i_tx_reset(rst), .i_link_up(link),
        .i_src_hdr_avail(hdr_avail), .i_src_hdr_len(hdr_len), .o_src_hdr_pop(hdr_pop),
        .i_src_data(sdata), .i_src_bytes_valid(sbv), .o_src_data_pop(data_pop),
        .o_tx_bus(txb), .o_grant_valid(gv), .o_grant_idx(gidx),
        .o_frames_sent(fsent), .o_frames_dropped(fdrop)
    );

    // Source FIFO models: pop seen at an edge, data on the outputs two edges later.
    logic [10:0] hq0[$], hq1[$];
    logic [34:0] dq0[$], dq1[$];
    assign sdata = {d_out[1][34:3], d_out[0][34:3]};
    assign sbv   = {d_out[1][2:0], d_out[0][2:0]};
    always @(posedge clk) begin
        if (hdr_pop[0] && hq0.size() != 0) h_s1[0] <= hq0.pop_front();
        if (hdr_pop[1] && hq1.size() != 0) h_s1[1] <= hq1.pop_front();
        if (data_pop[0] && dq0.size() != 0) d_s1[0] <= dq0.pop_front();
        if (data_pop[1] && dq1.size() != 0) d_s1[1] <= dq1.pop_front();
        hdr_len   <= h_s1;
        d_out     <= d_s1;
        hdr_avail <= {hq1.size() != 0, hq0.size() != 0};
    end

    // Monitor: gathers observations only; all judging happens in the main sequence.
    int cyc = 0, beats = 0, mism = 0, idle_err = 0, multi = 0;
    int t_pop_rise = 0, t_start = 0, t_last_beat = 0, min_gap = 1000, idle_run = 0;
    int hpops[2] = '{0, 0}, dpops[2] = '{0, 0};
    bit seen_beat = 0, gv_d = 0, dpop_d = 0;
    logic [34:0] expq[$];
    int grants[$];
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        logic [34:0] ew;
        if ($countones({hdr_pop, data_pop}) > 1) multi++;
        for (int s = 0; s < 2; s++) begin
            if (hdr_pop[s]) hpops[s]++;
            if (data_pop[s]) dpops[s]++;
        end
        if (data_pop != 0 && !dpop_d) t_pop_rise = cyc;
        dpop_d = |data_pop;
        if (gv && !gv_d) grants.push_back(int'(gidx));
        gv_d = gv;
        if (txb.data_valid) begin
            beats++;
            t_last_beat = cyc;
            if (txb.start) begin
                t_start = cyc;
                if (seen_beat && idle_run < min_gap) min_gap = idle_run;
            end
            seen_beat = 1;
            idle_run  = 0;
            if (expq.size() == 0) mism++;
            else begin
                ew = expq.pop_front();
                if (ew != {txb.data, txb.bytes_valid}) mism++;
            end
        end else begin
            idle_run++;
            if (txb.start || txb.data != 0 || txb.bytes_valid != 0) idle_err++;
        end
    end

    int n_chk = 0, n_fail = 0;
    task automatic check(input string name, input longint act, input longint req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic push_frame(input int src, input int len, input int tag, input int nexp);
        logic [34:0] w;
        if (src == 0) hq0.push_back(11'(len)); else hq1.push_back(11'(len));
        for (int k = 0; k < len; k++) begin
            w = {8'(tag), 8'(src), 16'(k), (k == len - 1) ? 3'd2 : 3'd4};
            if (src == 0) dq0.push_back(w); else dq1.push_back(w);
            if (k < nexp) expq.push_back(w);
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        int quiet = 0, n = 0;
        while (quiet < 4 && n < budget) begin
            @(negedge clk);
            n++;
            if (!gv && hq0.size() == 0 && hq1.size() == 0 && hdr_pop == 0 && data_pop == 0) quiet++;
            else quiet = 0;
        end
        check({name, " completes"}, longint'(n < budget), 1);
    endtask

    typedef struct {int src; int len; int exp_beats; int exp_sent; int exp_drop;} vec_t;
    vec_t vt[8];
    int s_sent, s_drop, s_beats, s_mism, s_h, s_d, n, cnt;

    initial begin
        vt[0] = '{1, 3, 3, 1, 0};
        vt[1] = '{0, 1, 1, 1, 0};
        vt[2] = '{1, 0, 0, 0, 0};
        vt[3] = '{0, 2, 2, 1, 0};
        vt[4] = '{0, 1024, 1024, 1, 0};
        vt[5] = '{0, 1025, 0, 0, 1};
        vt[6] = '{0, 1100, 0, 0, 1};
        vt[7] = '{1, 2, 2, 1, 0};

        rst = 1'b1; link = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset hdr_pop", hdr_pop, 0);
        check("reset data_pop", data_pop, 0);
        check("reset tx_bus", txb, 0);
        check("reset grant_valid", gv, 0);
        check("reset grant_idx", gidx, 0);
        check("reset frames_sent", fsent, 0);
        check("reset frames_dropped", fdrop, 0);
        rst = 1'b0;

        // Round robin from pointer 0 with both sources backlogged.
        for (int f = 0; f < 3; f++) begin
            push_frame(0, 3, 16 + f, 3);
            push_frame(1, 3, 32 + f, 3);
        end
        wait_idle("rr", 600);
        check("rr grant count", grants.size(), 6);
        for (int i = 0; i < 6; i++)
            check("rr grant order", (i < grants.size()) ? grants[i] : -1, i % 2);
        check("rr frames_sent", fsent, 6);
        check("rr beat mismatches", mism, 0);
        check("rr min idle gap ok", longint'(min_gap >= 3), 1);

        // Single 4-word frame: latency and contiguity.
        s_sent = fsent; s_d = dpops[0]; s_beats = beats;
        push_frame(0, 4, 33, 4);
        wait_idle("len4", 200);
        check("len4 data pops", dpops[0] - s_d, 4);
        check("len4 beats", beats - s_beats, 4);
        check("len4 start latency", t_start - t_pop_rise, 3);
        check("len4 contiguous", t_last_beat - t_start, 3);
        check("len4 frames_sent", int'(fsent) - s_sent, 1);

        foreach (vt[i]) begin
            s_sent = fsent; s_drop = fdrop; s_beats = beats; s_mism = mism;
            s_h = hpops[vt[i].src]; s_d = dpops[vt[i].src];
            push_frame(vt[i].src, vt[i].len, 64 + i, vt[i].exp_beats);
            wait_idle($sformatf("vec%0d", i), vt[i].len + 200);
            check($sformatf("vec%0d hdr pops", i), hpops[vt[i].src] - s_h, 1);
            check($sformatf("vec%0d data pops", i), dpops[vt[i].src] - s_d, vt[i].len);
            check($sformatf("vec%0d beats", i), beats - s_beats, vt[i].exp_beats);
            check($sformatf("vec%0d sent", i), int'(fsent) - s_sent, vt[i].exp_sent);
            check($sformatf("vec%0d dropped", i), int'(fdrop) - s_drop, vt[i].exp_drop);
            check($sformatf("vec%0d mismatches", i), mism - s_mism, 0);
        end

        // Link loss while beat 5 of 10 is popped.
        s_sent = fsent; s_drop = fdrop; s_beats = beats; s_mism = mism; s_d = dpops[0];
        push_frame(0, 10, 85, 5);
        n = 0; cnt = 0;
        while (n < 5 && cnt < 200) begin
            @(posedge clk); #1; cnt++;
            if (data_pop[0]) n++;
        end
        link = 1'b0;
        check("linkdn pops before drop", n, 5);
        push_frame(1, 2, 86, 2);
        cnt = 0;
        while (gv && cnt < 100) begin @(negedge clk); cnt++; end
        check("linkdn frame ends", gv, 0);
        s_h = hpops[1];
        repeat (30) @(negedge clk);
        check("linkdn no new grant", hpops[1] - s_h, 0);
        check("linkdn data pops", dpops[0] - s_d, 10);
        check("linkdn beats", beats - s_beats, 5);
        check("linkdn dropped", int'(fdrop) - s_drop, 1);
        check("linkdn sent", int'(fsent) - s_sent, 0);
        link = 1'b1;
        wait_idle("linkup", 200);
        check("linkup sent", int'(fsent) - s_sent, 1);
        check("linkup mismatches", mism - s_mism, 0);

        // Reset in the middle of SEND.
        push_frame(0, 20, 87, 20);
        n = 0; cnt = 0;
        while (n < 6 && cnt < 200) begin
            @(posedge clk); #1; cnt++;
            if (data_pop[0]) n++;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        check("midreset hdr_pop", hdr_pop, 0);
        check("midreset data_pop", data_pop, 0);
        check("midreset tx_bus", txb, 0);
        check("midreset grant_valid", gv, 0);
        check("midreset frames_sent", fsent, 0);
        check("midreset frames_dropped", fdrop, 0);
        hq0.delete(); dq0.delete(); expq.delete();
        rst = 1'b0;
        s_mism = mism;
        push_frame(0, 2, 88, 2);
        wait_idle("postreset", 200);
        check("postreset frames_sent", fsent, 1);
        check("postreset mismatches", mism - s_mism, 0);
        check("postreset scoreboard drained", expq.size(), 0);

        check("single pop per cycle", multi, 0);
        check("idle bus clean", idle_err, 0);
        check("final min idle gap ok", longint'(min_gap >= 3), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
